// File: rtl/clockgater_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clockgater_ctrl
// Purpose  : N-channel auto clock-gating controller with quiesce handshake.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// clockgater_ctrl_cell : latch-AND gate; enable is captured while clk is low.
// ----------------------------------------------------------------------------
module clockgater_ctrl_cell (
    input  logic clk,
    input  logic en_i,
    output logic eclk_o
);

    logic en_lat_q;

    always_latch begin
        if (!clk) begin
            en_lat_q <= en_i;
        end
    end

    assign eclk_o = en_lat_q & clk;

endmodule

// ----------------------------------------------------------------------------
// clockgater_ctrl : per-channel RUN/DRAIN/GATED/WAKE FSM with idle counter.
// ----------------------------------------------------------------------------
module clockgater_ctrl #(
    parameter bit FPGA  = 1'b0,
    parameter int N     = 4,
    parameter int IDLEW = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             GateEn_i,
    input  logic [IDLEW-1:0] IdleThresh_i,
    input  logic [N-1:0]     Activity_i,
    input  logic [N-1:0]     ForceOn_i,
    input  logic             SE_i,
    input  logic [N-1:0]     GateAck_i,
    output logic [N-1:0]     GateReq_o,
    output logic [N-1:0]     Gated_o,
    output logic [N-1:0]     ECLK_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    localparam logic [IDLEW-1:0] c_CNT_MAX = '1;
    localparam logic [IDLEW:0]   c_ONE_EXT = (IDLEW+1)'(1);

    logic           w_global_wake;
    logic [IDLEW:0] w_thresh_ext;

    assign w_global_wake = ~GateEn_i | (IdleThresh_i == '0);
    assign w_thresh_ext  = {1'b0, IdleThresh_i};

    for (genvar g = 0; g < N; g++) begin : g_ch
        state_e           state_q, state_d;
        logic [IDLEW-1:0] cnt_q, cnt_d;
        logic             w_wake;
        logic             w_idle_done;
        logic             w_en;

        assign w_wake = Activity_i[g] | ForceOn_i[g] | w_global_wake;
        // Extended compare so a saturated count still meets an all-ones threshold.
        assign w_idle_done = (({1'b0, cnt_q} + c_ONE_EXT) >= w_thresh_ext);

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state_q <= ST_RUN;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_RUN: begin
                    if (w_wake) begin
                        cnt_d = '0;
                    end else begin
                        if (cnt_q != c_CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (w_idle_done) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_wake) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else if (GateAck_i[g]) begin
                        state_d = ST_GATED;
                    end
                end
                ST_GATED: begin
                    if (w_wake) begin
                        state_d = ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end

        assign GateReq_o[g] = (state_q == ST_DRAIN);
        assign Gated_o[g]   = (state_q == ST_GATED) | (state_q == ST_WAKE);
        // Reset forces the enable so gated units see clocks during reset.
        assign w_en         = (state_q != ST_GATED) | SE_i | ~reset_n;

        if (FPGA) begin : g_fpga
`ifdef CLOCKGATER_XILINX_PRIMS
            BUFGCE u_bufgce (
                .I  (clk),
                .CE (w_en),
                .O  (ECLK_o[g])
            );
`else
            clockgater_ctrl_cell u_cell (
                .clk    (clk),
                .en_i   (w_en),
                .eclk_o (ECLK_o[g])
            );
`endif
        end else begin : g_latch
            clockgater_ctrl_cell u_cell (
                .clk    (clk),
                .en_i   (w_en),
                .eclk_o (ECLK_o[g])
            );
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clockgater_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clockgater_ctrl
// Purpose  : Directed vector table plus long idle sequences for clockgater_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clockgater_ctrl;

    localparam int N     = 4;
    localparam int IDLEW = 8;

    logic             clk;
    logic             reset_n;
    logic             GateEn;
    logic [IDLEW-1:0] IdleThresh;
    logic [N-1:0]     Activity;
    logic [N-1:0]     ForceOn;
    logic             SE;
    logic [N-1:0]     GateAck;
    logic [N-1:0]     GateReq;
    logic [N-1:0]     Gated;
    logic [N-1:0]     ECLK;

    clockgater_ctrl #(
        .FPGA  (1'b0),
        .N     (N),
        .IDLEW (IDLEW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .GateEn_i     (GateEn),
        .IdleThresh_i (IdleThresh),
        .Activity_i   (Activity),
        .ForceOn_i    (ForceOn),
        .SE_i         (SE),
        .GateAck_i    (GateAck),
        .GateReq_o    (GateReq),
        .Gated_o      (Gated),
        .ECLK_o       (ECLK)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic             rst_n;
        logic             gen;
        logic [IDLEW-1:0] thr;
        logic [N-1:0]     act;
        logic [N-1:0]     frc;
        logic             se;
        logic [N-1:0]     ack;
        logic [N-1:0]     exp_req;
        logic [N-1:0]     exp_gated;
        logic [N-1:0]     exp_eclk;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    function automatic void add(input logic rst_n, input logic gen, input logic [IDLEW-1:0] thr,
                                input logic [N-1:0] act, input logic [N-1:0] frc, input logic se,
                                input logic [N-1:0] ack, input logic [N-1:0] req,
                                input logic [N-1:0] gated, input logic [N-1:0] eclk);
        vec_t v;
        v.rst_n = rst_n; v.gen = gen; v.thr = thr; v.act = act; v.frc = frc;
        v.se = se; v.ack = ack; v.exp_req = req; v.exp_gated = gated; v.exp_eclk = eclk;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [N-1:0] got,
                         input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, got, exp);
        end
    endtask

    // Drive in the low phase, sample 1 ns after the rising edge: ECLK high
    // then means the pulse at that edge was delivered.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        reset_n    = v.rst_n;
        GateEn     = v.gen;
        IdleThresh = v.thr;
        Activity   = v.act;
        ForceOn    = v.frc;
        SE         = v.se;
        GateAck    = v.ack;
        @(posedge clk);
        #1;
        check("GateReq", idx, GateReq, v.exp_req);
        check("Gated",   idx, Gated,   v.exp_gated);
        check("ECLK",    idx, ECLK,    v.exp_eclk);
    endtask

    initial begin
        vec_t v;
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        GateEn     = 1'b1;
        IdleThresh = 8'd4;
        Activity   = '0;
        ForceOn    = '0;
        SE         = 1'b0;
        GateAck    = '0;

        //  rst gen thr    act      frc      se   ack        req      gated    eclk
        // reset
        for (int i = 0; i < 3; i++)
            add(1'b0, 1'b1, 8'd4, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        // auto-gate ch0 with threshold 4
        add(1'b1, 1'b1, 8'd4, 4'b1110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd4, 4'b1110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd4, 4'b1110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd4, 4'b1110, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd4, 4'b1110, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b1111);
        add(1'b1, 1'b1, 8'd4, 4'b1110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b1110);
        add(1'b1, 1'b1, 8'd4, 4'b1110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b1110);
        // wake ch0
        add(1'b1, 1'b1, 8'd4, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b1110);
        add(1'b1, 1'b1, 8'd4, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        // abort on ch1: ack and activity in the same DRAIN cycle
        add(1'b1, 1'b1, 8'd2, 4'b1101, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd2, 4'b1101, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd2, 4'b1111, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd2, 4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        // threshold 1, then scan enable while gated
        add(1'b1, 1'b1, 8'd1, 4'b1110, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd1, 4'b1110, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b1111);
        add(1'b1, 1'b1, 8'd1, 4'b1110, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b1111);
        add(1'b1, 1'b1, 8'd1, 4'b1110, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b1111);
        add(1'b1, 1'b1, 8'd1, 4'b1110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b1110);
        // gate all channels, then reset while gated
        add(1'b1, 1'b1, 8'd1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1110, 4'b0001, 4'b1110);
        add(1'b1, 1'b1, 8'd1, 4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b1110);
        add(1'b1, 1'b1, 8'd1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        add(1'b0, 1'b1, 8'd1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        // threshold lowered mid-count
        add(1'b1, 1'b1, 8'd10, 4'b1110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd10, 4'b1110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd10, 4'b1110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd3, 4'b1110, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd3, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        // ForceOn aborts DRAIN
        add(1'b1, 1'b1, 8'd1, 4'b1110, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b1111);
        add(1'b1, 1'b1, 8'd1, 4'b1110, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);

        foreach (vecs[i]) begin
            apply(vecs[i], i);
        end

        // GateEn=0 keeps every idle channel running
        for (int i = 0; i < 300; i++) begin
            add(1'b1, 1'b0, 8'd1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
            v = vecs[vecs.size()-1];
            apply(v, 1000 + i);
        end
        // IdleThresh=0 disables gating
        for (int i = 0; i < 300; i++) begin
            add(1'b1, 1'b1, 8'd0, 4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
            v = vecs[vecs.size()-1];
            apply(v, 2000 + i);
        end
        // all-ones threshold: DRAIN on the 255th consecutive idle edge
        for (int i = 0; i < 256; i++) begin
            add(1'b1, 1'b1, 8'hFF, 4'b1110, 4'b0000, 1'b0, 4'b0000,
                (i >= 254) ? 4'b0001 : 4'b0000, 4'b0000, 4'b1111);
            v = vecs[vecs.size()-1];
            apply(v, 3000 + i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
